// File: rtl/rcs_serial_4_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type and default width.
package rcs_serial_4_pkg;

    parameter int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/rcs_serial_4_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master drives operands and result acceptance; the slave is the subtractor.
interface rcs_serial_4_if
    import rcs_serial_4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, diff, bout
    );

endinterface

// File: rtl/rcs_serial_4_full_subtractor1.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
// Combinational mirror of the full_adder1 cell.
module full_subtractor1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/rcs_serial_4.sv
// Bit-serial subtractor: D = A - B - Bin computed LSB first, one bit per clock,
// through a single full-subtractor cell and a registered borrow.
// Valid/ready handshakes on both sides; one operation in flight at a time.
module rcs_serial_4
    import rcs_serial_4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    rcs_serial_4_if.slave     bus
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   diff_sh;
    logic               brw;
    logic [CNT_W-1:0]   cnt;
    logic               d_bit;
    logic               brw_bit;
    logic               in_ready_c;
    logic               out_valid_c;

    full_subtractor1 u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .d    (d_bit),
        .bout (brw_bit)
    );

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs derived from the current state.
    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands in IDLE, then shift one bit per cycle in SHIFT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            brw     <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh <= bus.A;
                        b_sh <= bus.B;
                        brw  <= bus.Bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= {d_bit, diff_sh[WIDTH-1:1]};
                    brw     <= brw_bit;
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.diff      = diff_sh;
    assign bus.bout      = brw;

endmodule

// File: tb/tb_rcs_serial_4.sv
// Scoreboard bench for rcs_serial_4: WIDTH=4 and WIDTH=8 instances.
// Stimulus pushes arithmetic expectations; negedge monitors pop and compare.
module tb_rcs_serial_4;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;

    exp_t q4[$];
    exp_t q8[$];

    bit         prev_v[2];
    bit         ready_chk[2];
    logic [7:0] held_d[2];
    logic       held_b[2];

    rcs_serial_4_if #(.WIDTH(4)) bus4 ();
    rcs_serial_4_if #(.WIDTH(8)) bus8 ();

    rcs_serial_4 #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    rcs_serial_4 #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Random result backpressure on the 4-bit instance when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) bus4.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input int id, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s (dut%0d): got %0h required %0h", name, id, act, req);
        end
    endtask

    // Reference: plain integer subtraction, wrapped to the operand width.
    function automatic exp_t model(input int w, input int a, input int b, input int bin, input int acc);
        exp_t e;
        int   d;
        d      = a - b - bin;
        e.bout = (d < 0);
        e.diff = 8'(d & ((1 << w) - 1));
        e.acc  = acc;
        return e;
    endfunction

    task automatic applyStimulus(input int id, input int a, input int b, input logic bin);
        bit done = 1'b0;
        int tries = 0;
        while (!done && tries < 300) begin
            @(posedge clk); #1;
            if (id == 0) begin
                bus4.in_valid = 1'b1; bus4.A = 4'(a); bus4.B = 4'(b); bus4.Bin = bin;
            end else begin
                bus8.in_valid = 1'b1; bus8.A = 8'(a); bus8.B = 8'(b); bus8.Bin = bin;
            end
            @(negedge clk);
            if (id == 0 && bus4.in_ready) begin
                q4.push_back(model(4, a, b, int'(bin), cyc + 1));
                done = 1'b1;
            end else if (id == 1 && bus8.in_ready) begin
                q8.push_back(model(8, a, b, int'(bin), cyc + 1));
                done = 1'b1;
            end
            tries++;
        end
        @(posedge clk); #1;
        if (id == 0) bus4.in_valid = 1'b0;
        else         bus8.in_valid = 1'b0;
        check("accepted", id, int'(done), 1);
    endtask

    task automatic checkOutput(input int id, input int w, input logic ov, input logic orr,
                               input logic [7:0] d, input logic bo, input logic ir);
        exp_t e;
        int   qsize;
        qsize = (id == 0) ? q4.size() : q8.size();
        if (ready_chk[id]) begin
            check("in_ready_after_done", id, int'(ir), 1);
            ready_chk[id] = 1'b0;
        end
        if (ov) begin
            if (!prev_v[id]) begin
                check("result_expected", id, int'(qsize != 0), 1);
                if (qsize != 0) begin
                    e = (id == 0) ? q4[0] : q8[0];
                    check("latency_edges", id, cyc - e.acc, w);
                    check("diff", id, int'(d), int'(e.diff));
                    check("bout", id, int'(bo), int'(e.bout));
                end
                held_d[id] = d;
                held_b[id] = bo;
            end else begin
                check("diff_stable", id, int'(d), int'(held_d[id]));
                check("bout_stable", id, int'(bo), int'(held_b[id]));
            end
            if (orr) begin
                if (qsize != 0) begin
                    if (id == 0) void'(q4.pop_front());
                    else         void'(q8.pop_front());
                end
                ready_chk[id] = 1'b1;
                prev_v[id]    = 1'b0;
            end else begin
                prev_v[id] = 1'b1;
            end
        end else begin
            if (prev_v[id]) check("valid_held", id, int'(ov), 1);
            prev_v[id] = 1'b0;
        end
    endtask

    // Output monitor: compares every presented result against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v[0] = 1'b0; ready_chk[0] = 1'b0;
            prev_v[1] = 1'b0; ready_chk[1] = 1'b0;
        end else begin
            checkOutput(0, 4, bus4.out_valid, bus4.out_ready, {4'b0, bus4.diff}, bus4.bout, bus4.in_ready);
            checkOutput(1, 8, bus8.out_valid, bus8.out_ready, bus8.diff, bus8.bout, bus8.in_ready);
        end
    end

    task automatic waitDrain(input int id);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (id == 0 && q4.size() == 0 && !bus4.out_valid) break;
            if (id == 1 && q8.size() == 0 && !bus8.out_valid) break;
        end
        check("drain_pending", id, (id == 0) ? q4.size() : q8.size(), 0);
    endtask

    task automatic checkResetState(input int id);
        if (id == 0) begin
            check("rst_in_ready", 0, int'(bus4.in_ready), 1);
            check("rst_out_valid", 0, int'(bus4.out_valid), 0);
            check("rst_diff", 0, int'(bus4.diff), 0);
            check("rst_bout", 0, int'(bus4.bout), 0);
        end else begin
            check("rst_in_ready", 1, int'(bus8.in_ready), 1);
            check("rst_out_valid", 1, int'(bus8.out_valid), 0);
            check("rst_diff", 1, int'(bus8.diff), 0);
            check("rst_bout", 1, int'(bus8.bout), 0);
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus4.in_valid = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Bin = 1'b0; bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Bin = 1'b0; bus8.out_ready = 1'b1;

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetState(0);
        checkResetState(1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset in the 2nd SHIFT cycle discards the operation
        applyStimulus(0, 9, 3, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        q4.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkResetState(0);
        repeat (12) @(negedge clk);

        // Basic, underflow, equal operands with borrow-in
        applyStimulus(0, 9, 3, 1'b0);
        waitDrain(0);
        applyStimulus(0, 0, 1, 1'b0);
        applyStimulus(0, 5, 5, 1'b1);
        applyStimulus(0, 5, 5, 1'b0);
        waitDrain(0);

        // Backpressure in DONE with ignored in_valid pulses while busy
        bus4.out_ready = 1'b0;
        applyStimulus(0, 12, 7, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            bus4.in_valid = (i % 2 == 0);
            bus4.A = 4'd1; bus4.B = 4'd1; bus4.Bin = 1'b0;
            @(negedge clk);
            check("busy_in_ready", 0, int'(bus4.in_ready), 0);
        end
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        waitDrain(0);

        // Exhaustive 4-bit sweep under random backpressure
        rand_ready = 1'b1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bin = 0; bin < 2; bin++)
                    applyStimulus(0, a, b, 1'(bin));
        @(posedge clk); #1;
        rand_ready = 1'b0;
        bus4.out_ready = 1'b1;
        waitDrain(0);

        // Wide instance: borrow through every bit, then random operands
        applyStimulus(1, 8'h00, 8'hFF, 1'b1);
        waitDrain(1);
        for (int k = 0; k < 8; k++)
            applyStimulus(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        waitDrain(1);

        check("final_q4_empty", 0, q4.size(), 0);
        check("final_q8_empty", 1, q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
